// File: rtl/fetch_unit.sv
// Instruction fetch and addressing-mode resolution for an 8-bit CPU core.
// Walks the reset vector, then per instruction fetches opcode/operands and resolves eff_addr.
module fetch_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  input  logic [REG_WIDTH-1:0]  x_in,
  input  logic [REG_WIDTH-1:0]  y_in,
  input  logic                  instruction_done,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_value,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic [REG_WIDTH-1:0]  instruction,
  output logic [REG_WIDTH-1:0]  operand,
  output logic [ADDR_WIDTH-1:0] eff_addr,
  output logic                  instruction_ready,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_VEC_LO = 3'd0,
    S_VEC_HI = 3'd1,
    S_OP     = 3'd2,
    S_OPR1   = 3'd3,
    S_OPR2   = 3'd4,
    S_PTR_LO = 3'd5,
    S_PTR_HI = 3'd6,
    S_READY  = 3'd7
  } state_t;

  localparam logic [2:0] M_IZX  = 3'b000;
  localparam logic [2:0] M_IMM  = 3'b010;
  localparam logic [2:0] M_ABS  = 3'b011;
  localparam logic [2:0] M_IZY  = 3'b100;
  localparam logic [2:0] M_ZPGX = 3'b101;
  localparam logic [2:0] M_ABSY = 3'b110;
  localparam logic [2:0] M_ABSX = 3'b111;

  state_t               state, state_next;
  logic [2:0]           mode;
  logic [REG_WIDTH-1:0] index_val;
  logic [REG_WIDTH-1:0] zp_addr;
  logic [REG_WIDTH-1:0] ptr_addr;
  logic [REG_WIDTH-1:0] ptr_lo;

  function automatic logic [ADDR_WIDTH-1:0] zext(input logic [REG_WIDTH-1:0] v);
    return {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, v};
  endfunction

  assign mode      = instruction[4:2];
  assign dbg_state = state;

  // Handshake: instruction_ready is high for the whole READY state and the
  // outputs stay frozen; an instruction_done seen high at a rising edge while
  // ready is high retires the instruction. instruction_done is ignored otherwise.
  assign instruction_ready = (state == S_READY);

  // Index register applied after the base address is known; zero for the
  // modes that do not index (and for (zp,X), whose X is folded into the pointer).
  always_comb begin
    index_val = '0;
    case (mode)
      M_ZPGX, M_ABSX: index_val = x_in;
      M_ABSY, M_IZY:  index_val = y_in;
      default:        index_val = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    mem_addr   = pc;
    mem_rd     = 1'b1;
    zp_addr    = operand;
    case (state)
      S_VEC_LO: begin
        mem_addr   = RESET_VECTOR;
        state_next = S_VEC_HI;
      end
      S_VEC_HI: begin
        mem_addr   = RESET_VECTOR + ADDR_WIDTH'(1);
        state_next = S_OP;
      end
      S_OP: state_next = S_OPR1;
      S_OPR1: begin
        case (mode)
          M_ABS, M_ABSX, M_ABSY: state_next = S_OPR2;
          M_IZX, M_IZY:          state_next = S_PTR_LO;
          default:               state_next = S_READY;
        endcase
      end
      S_OPR2: state_next = S_READY;
      S_PTR_LO: begin
        zp_addr    = (mode == M_IZX) ? operand + x_in : operand;
        mem_addr   = zext(zp_addr);
        state_next = S_PTR_HI;
      end
      S_PTR_HI: begin
        zp_addr    = ptr_addr + REG_WIDTH'(1);
        mem_addr   = zext(zp_addr);
        state_next = S_READY;
      end
      S_READY: begin
        mem_rd = 1'b0;
        if (instruction_done) state_next = S_OP;
      end
      default: state_next = S_VEC_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_VEC_LO;
      pc          <= '0;
      instruction <= '0;
      operand     <= '0;
      eff_addr    <= '0;
      ptr_addr    <= '0;
      ptr_lo      <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_VEC_LO: pc[REG_WIDTH-1:0]          <= mem_rdata;
        S_VEC_HI: pc[ADDR_WIDTH-1:REG_WIDTH] <= mem_rdata;
        S_OP: begin
          instruction <= mem_rdata;
          pc          <= pc + ADDR_WIDTH'(1);
        end
        S_OPR1: begin
          operand <= mem_rdata;
          pc      <= pc + ADDR_WIDTH'(1);
          // Zero-page modes resolve here; index_val is zero for plain zpg.
          if (mode == M_IMM) eff_addr <= pc;
          else if (mode == 3'b001 || mode == M_ZPGX) eff_addr <= zext(mem_rdata + index_val);
        end
        S_OPR2: begin
          pc       <= pc + ADDR_WIDTH'(1);
          eff_addr <= {mem_rdata, operand} + zext(index_val);
        end
        S_PTR_LO: begin
          ptr_addr <= zp_addr;
          ptr_lo   <= mem_rdata;
        end
        S_PTR_HI: eff_addr <= {mem_rdata, ptr_lo} + zext(index_val);
        S_READY: if (instruction_done && pc_load) pc <= pc_load_value;
        default: ;
      endcase
    end
  end

endmodule
